// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-stage FSM states and default datapath widths
// used by the PC unit, instruction memory and decoder.
package cpu_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALT} pc_state_t;

    localparam int PC_WIDTH_DEF       = 10;
    localparam int LUT_ADDR_WIDTH_DEF = 5;
    localparam int CNT_WIDTH_DEF      = 16;

    // A jump always redirects; a conditional branch redirects only on a set flag.
    function automatic logic is_redirect(input logic branch, input logic jump,
                                         input logic cond);
        return jump | (branch & cond);
    endfunction

endpackage

// File: rtl/pc_unit_branch_lut.sv
// Programmable branch-target table: register array with async clear,
// one clocked write port and one combinational read port.
module branch_lut #(
    parameter int ADDR_WIDTH = cpu_pkg::LUT_ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH = cpu_pkg::PC_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_idx,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] entries [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (wr_en) begin
            entries[wr_idx] <= wr_data;
        end
    end

    // Same-cycle write and read of one index sees the pre-write entry.
    assign rd_data = entries[rd_idx];

endmodule

// File: rtl/pc_unit.sv
// Program counter, next-PC selection, run/halt control FSM and
// retired-instruction counter for the stage after the ALU.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int          PC_WIDTH       = PC_WIDTH_DEF,
    parameter int          LUT_ADDR_WIDTH = LUT_ADDR_WIDTH_DEF,
    parameter int unsigned START_ADDR     = 0,
    parameter int          CNT_WIDTH      = CNT_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stall,
    input  logic                      halt_req,
    input  logic                      branch,
    input  logic                      jump,
    input  logic [7:0]                alu_out,
    input  logic [LUT_ADDR_WIDTH-1:0] lut_idx,
    input  logic                      lut_wr_en,
    input  logic [LUT_ADDR_WIDTH-1:0] lut_wr_idx,
    input  logic [PC_WIDTH-1:0]       lut_wr_data,
    output logic [PC_WIDTH-1:0]       pc_out,
    output logic                      running,
    output logic                      done,
    output logic                      taken_q,
    output logic [CNT_WIDTH-1:0]      instr_count
);

    localparam logic [PC_WIDTH-1:0] START_PC = PC_WIDTH'(START_ADDR);

    pc_state_t             state;
    logic [PC_WIDTH-1:0]   target_pc;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic                  redirect;
    logic                  unused_alu_bits;

    branch_lut #(
        .ADDR_WIDTH (LUT_ADDR_WIDTH),
        .DATA_WIDTH (PC_WIDTH)
    ) u_lut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (lut_wr_en),
        .wr_idx  (lut_wr_idx),
        .wr_data (lut_wr_data),
        .rd_idx  (lut_idx),
        .rd_data (target_pc)
    );

    // Only the flag bit of the ALU result carries meaning here.
    assign unused_alu_bits = ^alu_out[7:1];
    assign redirect        = is_redirect(branch, jump, alu_out[0]);
    assign count_inc       = (&instr_count) ? instr_count : instr_count + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc_out      <= START_PC;
            taken_q     <= 1'b0;
            instr_count <= '0;
        end else begin
            taken_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        instr_count <= count_inc;
                        if (halt_req) begin
                            state <= HALT;
                        end else if (redirect) begin
                            pc_out  <= target_pc;
                            taken_q <= 1'b1;
                        end else begin
                            pc_out <= pc_out + 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (start) begin
                        pc_out      <= START_PC;
                        instr_count <= '0;
                        state       <= RUN;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign running = (state == RUN);
    assign done    = (state == HALT);

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: a reference model pushes expected outputs
// to a scoreboard queue each cycle, popped and compared after the clock edge.
module tb_pc_unit;

    typedef struct packed {
        logic [9:0]  pc;
        logic        taken;
        logic [15:0] cnt;
        logic        running;
        logic        done;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        stall;
    logic        halt_req;
    logic        branch;
    logic        jump;
    logic [7:0]  alu_out;
    logic [4:0]  lut_idx;
    logic        lut_wr_en;
    logic [4:0]  lut_wr_idx;
    logic [9:0]  lut_wr_data;
    logic [9:0]  pc_out;
    logic        running;
    logic        done;
    logic        taken_q;
    logic [15:0] instr_count;

    int assertions = 0;
    int failures   = 0;
    int cycle_no   = 0;

    exp_t scoreboard[$];

    int         m_state;
    logic [9:0] m_pc;
    logic       m_taken;
    logic [15:0] m_cnt;
    logic [9:0] m_lut [32];

    pc_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .halt_req    (halt_req),
        .branch      (branch),
        .jump        (jump),
        .alu_out     (alu_out),
        .lut_idx     (lut_idx),
        .lut_wr_en   (lut_wr_en),
        .lut_wr_idx  (lut_wr_idx),
        .lut_wr_data (lut_wr_data),
        .pc_out      (pc_out),
        .running     (running),
        .done        (done),
        .taken_q     (taken_q),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0;
        m_pc    = '0;
        m_taken = 1'b0;
        m_cnt   = '0;
        for (int i = 0; i < 32; i++) m_lut[i] = '0;
    endtask

    task automatic clear_inputs();
        start = 0; stall = 0; halt_req = 0; branch = 0; jump = 0;
        alu_out = '0; lut_idx = '0; lut_wr_en = 0; lut_wr_idx = '0; lut_wr_data = '0;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        logic [9:0] old_target;
        old_target = m_lut[lut_idx];
        m_taken = 1'b0;
        if (m_state == 0) begin
            if (start) m_state = 1;
        end else if (m_state == 1) begin
            if (!stall) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (halt_req) m_state = 2;
                else if (jump || (branch && alu_out[0])) begin
                    m_pc = old_target;
                    m_taken = 1'b1;
                end else m_pc = m_pc + 10'd1;
            end
        end else if (start) begin
            m_pc = '0;
            m_cnt = '0;
            m_state = 1;
        end
        if (lut_wr_en) m_lut[lut_wr_idx] = lut_wr_data;
    endtask

    // Drive one cycle: push the model's expectation, clock, pop and compare.
    task automatic applyStimulus();
        exp_t e;
        exp_t got;
        model_step();
        e = '{pc: m_pc, taken: m_taken, cnt: m_cnt,
              running: (m_state == 1), done: (m_state == 2)};
        scoreboard.push_back(e);
        @(posedge clk);
        #1;
        cycle_no++;
        e = scoreboard.pop_front();
        got = '{pc: pc_out, taken: taken_q, cnt: instr_count, running: running, done: done};
        assertions++;
        if (got !== e) begin
            failures++;
            $display("[TB] FAIL scoreboard cycle %0d: got pc=%h taken=%b cnt=%0d run=%b done=%b, want pc=%h taken=%b cnt=%0d run=%b done=%b",
                     cycle_no, got.pc, got.taken, got.cnt, got.running, got.done,
                     e.pc, e.taken, e.cnt, e.running, e.done);
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        #12;
        assertions++;
        if ({pc_out, running, done, taken_q, instr_count} !== 29'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got pc=%h run=%b done=%b taken=%b cnt=%0d, want all zero",
                     pc_out, running, done, taken_q, instr_count);
        end
        reset = 1'b0;
        start = 1;
        applyStimulus();
        start = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                lut_wr_en = 1; lut_wr_idx = 5'd2; lut_wr_data = 10'h3AA;
            end
            applyStimulus();
        end
        clear_inputs();
        assertions++;
        if (pc_out !== 10'h005) begin
            failures++;
            $display("[TB] FAIL pre_abort_pc: got %h want 005", pc_out);
        end
        #2;
        reset = 1'b1;
        #1;
        assertions++;
        if (pc_out !== 10'h000 || running !== 1'b0 || instr_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL async_abort: got pc=%h run=%b cnt=%0d, want pc=000 run=0 cnt=0",
                     pc_out, running, instr_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_plain_run();
        start = 1;
        applyStimulus();
        assertions++;
        if (pc_out !== 10'h000 || running !== 1'b1) begin
            failures++;
            $display("[TB] FAIL first_fetch: got pc=%h run=%b want pc=000 run=1", pc_out, running);
        end
        start = 0;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            applyStimulus();
        end
        start = 0;
        assertions++;
        if (pc_out !== 10'h003 || instr_count !== 16'd3) begin
            failures++;
            $display("[TB] FAIL plain_run: got pc=%h cnt=%0d want pc=003 cnt=3", pc_out, instr_count);
        end
    endtask

    task automatic test_branch();
        lut_wr_en = 1; lut_wr_idx = 5'd4; lut_wr_data = 10'h120;
        applyStimulus();
        lut_wr_en = 0;
        branch = 1; alu_out = 8'h01; lut_idx = 5'd4;
        applyStimulus();
        assertions++;
        if (pc_out !== 10'h120 || taken_q !== 1'b1) begin
            failures++;
            $display("[TB] FAIL branch_taken: got pc=%h taken=%b want pc=120 taken=1", pc_out, taken_q);
        end
        alu_out = 8'hFE;
        applyStimulus();
        assertions++;
        if (pc_out !== 10'h121 || taken_q !== 1'b0) begin
            failures++;
            $display("[TB] FAIL branch_not_taken: got pc=%h taken=%b want pc=121 taken=0", pc_out, taken_q);
        end
        clear_inputs();
    endtask

    task automatic test_stall();
        branch = 1; alu_out = 8'h01; lut_idx = 5'd4; stall = 1;
        applyStimulus();
        applyStimulus();
        assertions++;
        if (pc_out !== 10'h121 || instr_count !== 16'd6) begin
            failures++;
            $display("[TB] FAIL stall_freeze: got pc=%h cnt=%0d want pc=121 cnt=6", pc_out, instr_count);
        end
        stall = 0;
        applyStimulus();
        assertions++;
        if (pc_out !== 10'h120 || taken_q !== 1'b1 || instr_count !== 16'd7) begin
            failures++;
            $display("[TB] FAIL stall_release: got pc=%h taken=%b cnt=%0d want pc=120 taken=1 cnt=7",
                     pc_out, taken_q, instr_count);
        end
        clear_inputs();
    endtask

    task automatic test_wrap_halt_restart();
        lut_wr_en = 1; lut_wr_idx = 5'd7; lut_wr_data = 10'h3FF;
        applyStimulus();
        lut_wr_en = 0;
        jump = 1; lut_idx = 5'd7;
        applyStimulus();
        jump = 0;
        applyStimulus();
        assertions++;
        if (pc_out !== 10'h000) begin
            failures++;
            $display("[TB] FAIL pc_wrap: got %h want 000", pc_out);
        end
        applyStimulus();
        halt_req = 1;
        applyStimulus();
        halt_req = 0;
        assertions++;
        if (done !== 1'b1 || pc_out !== 10'h001 || running !== 1'b0) begin
            failures++;
            $display("[TB] FAIL halt: got done=%b run=%b pc=%h want done=1 run=0 pc=001", done, running, pc_out);
        end
        jump = 1; branch = 1; alu_out = 8'h01;
        applyStimulus();
        clear_inputs();
        start = 1;
        applyStimulus();
        start = 0;
        assertions++;
        if (pc_out !== 10'h000 || running !== 1'b1 || instr_count !== 16'd0) begin
            failures++;
            $display("[TB] FAIL restart: got pc=%h run=%b cnt=%0d want pc=000 run=1 cnt=0",
                     pc_out, running, instr_count);
        end
    endtask

    task automatic test_lut_bypass();
        applyStimulus();
        lut_wr_en = 1; lut_wr_idx = 5'd2; lut_wr_data = 10'h055;
        jump = 1; lut_idx = 5'd2;
        applyStimulus();
        lut_wr_en = 0;
        assertions++;
        if (pc_out !== 10'h000) begin
            failures++;
            $display("[TB] FAIL lut_old_read: got %h want 000", pc_out);
        end
        applyStimulus();
        assertions++;
        if (pc_out !== 10'h055) begin
            failures++;
            $display("[TB] FAIL lut_new_read: got %h want 055", pc_out);
        end
        clear_inputs();
    endtask

    task automatic test_saturation();
        int iter;
        iter = 0;
        while (m_cnt != 16'hFFFF && iter < 70000) begin
            stall     = ($urandom_range(31) == 0);
            start     = $urandom_range(1);
            branch    = $urandom_range(1);
            jump      = ($urandom_range(7) == 0);
            alu_out   = 8'($urandom);
            lut_idx   = 5'($urandom);
            lut_wr_en = ($urandom_range(15) == 0);
            lut_wr_idx  = 5'($urandom);
            lut_wr_data = 10'($urandom);
            applyStimulus();
            iter++;
        end
        clear_inputs();
        assertions++;
        if (m_cnt != 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL saturation_budget: got count %0d want 65535 within 70000 cycles", m_cnt);
        end
        for (int i = 0; i < 3; i++) applyStimulus();
        assertions++;
        if (instr_count !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL count_saturate: got %h want ffff", instr_count);
        end
    endtask

    initial begin
        test_reset();
        test_plain_run();
        test_branch();
        test_stall();
        test_wrap_halt_restart();
        test_lut_bypass();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
